// File: rtl/eeprom_i2c_slave.sv
// 24C16-class I2C EEPROM responder: oversamples SCL/SDA on CLK, drives SDA open-drain.
// Defining EEPROM_SLAVE_WP_EN adds a WP input that blocks memory writes while still ACKing data.
module eeprom_i2c_slave #(
  parameter int         ADDR_W      = 11,
  parameter logic [3:0] DEV_ID      = 4'b1010,
  parameter int         PAGE_SIZE   = 16,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RESET,
`ifdef EEPROM_SLAVE_WP_EN
  input  logic              WP,
`endif
  input  logic              SCL,
  inout  wire               SDA,
  output logic              BUSY,
  output logic              WR_PULSE,
  output logic [ADDR_W-1:0] ADDR_PTR
);

  localparam int PAGE_BITS = $clog2(PAGE_SIZE);
  localparam int PG_W      = ADDR_W - 8;
  localparam int DEPTH     = 1 << ADDR_W;

  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, DEV_ACK, WORD_ADDR, WORD_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK
  } state_t;

  state_t            state_reg, state_next;
  logic [3:0]        bit_cnt_reg, bit_cnt_next;
  logic [7:0]        rx_shift_reg, rx_shift_next;
  logic [7:0]        tx_shift_reg, tx_shift_next;
  logic              sda_low_reg, sda_low_next;
  logic              busy_reg, busy_next;
  logic              rw_reg, rw_next;
  logic [PG_W-1:0]   page_reg, page_next;
  logic [ADDR_W-1:0] addr_ptr_reg, addr_ptr_next;
  logic              wr_pulse_reg;
  logic              mem_we;
  logic              write_en;
  logic [7:0]        rd_data_reg;
  logic [7:0]        mem_array [DEPTH];

  logic [SYNC_STAGES-1:0] scl_sync_reg, sda_sync_reg;
  logic                   scl_prev_reg, sda_prev_reg;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_cond, stop_cond;
  logic [7:0]             rx_byte;

  // Chains reset to 1 so an idle (pulled-up) bus produces no false START after reset.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      scl_sync_reg <= '1;
      sda_sync_reg <= '1;
      scl_prev_reg <= 1'b1;
      sda_prev_reg <= 1'b1;
    end else begin
      scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], SCL};
      sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], SDA};
      scl_prev_reg <= scl_s;
      sda_prev_reg <= sda_s;
    end
  end

  assign scl_s      = scl_sync_reg[SYNC_STAGES-1];
  assign sda_s      = sda_sync_reg[SYNC_STAGES-1];
  assign scl_rise   = scl_s & ~scl_prev_reg;
  assign scl_fall   = ~scl_s & scl_prev_reg;
  assign start_cond = scl_s & scl_prev_reg & sda_prev_reg & ~sda_s;
  assign stop_cond  = scl_s & scl_prev_reg & ~sda_prev_reg & sda_s;
  assign rx_byte    = {rx_shift_reg[6:0], sda_s};

`ifdef EEPROM_SLAVE_WP_EN
  assign write_en = ~WP;
`else
  assign write_en = 1'b1;
`endif

  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    rx_shift_next = rx_shift_reg;
    tx_shift_next = tx_shift_reg;
    sda_low_next  = sda_low_reg;
    busy_next     = busy_reg;
    rw_next       = rw_reg;
    page_next     = page_reg;
    addr_ptr_next = addr_ptr_reg;
    mem_we        = 1'b0;
    if (start_cond) begin
      state_next   = DEV_ADDR;
      bit_cnt_next = '0;
      sda_low_next = 1'b0;
      busy_next    = 1'b1;
    end else if (stop_cond) begin
      state_next   = IDLE;
      bit_cnt_next = '0;
      sda_low_next = 1'b0;
      busy_next    = 1'b0;
    end else begin
      case (state_reg)
        DEV_ADDR, WORD_ADDR, WR_DATA: begin
          if (scl_rise) begin
            rx_shift_next = rx_byte;
            bit_cnt_next  = bit_cnt_reg + 4'd1;
            if (bit_cnt_reg == 4'd7) begin
              bit_cnt_next = '0;
              case (state_reg)
                DEV_ADDR: begin
                  if (rx_byte[7:4] == DEV_ID) begin
                    state_next = DEV_ACK;
                    rw_next    = rx_byte[0];
                    if (!rx_byte[0]) page_next = rx_byte[PG_W:1];
                  end else begin
                    state_next = IDLE;
                  end
                end
                WORD_ADDR: begin
                  addr_ptr_next = {page_reg, rx_byte};
                  state_next    = WORD_ACK;
                end
                default: begin
                  // Page write: only the in-page offset advances, wrapping inside the page.
                  mem_we        = write_en;
                  addr_ptr_next = {addr_ptr_reg[ADDR_W-1:PAGE_BITS],
                                   addr_ptr_reg[PAGE_BITS-1:0] + PAGE_BITS'(1)};
                  state_next    = WR_ACK;
                end
              endcase
            end
          end
        end
        DEV_ACK, WORD_ACK, WR_ACK: begin
          if (scl_fall) begin
            if (bit_cnt_reg == 4'd0) begin
              sda_low_next = 1'b1;
              bit_cnt_next = 4'd1;
            end else begin
              sda_low_next = 1'b0;
              bit_cnt_next = '0;
              if (state_reg == DEV_ACK && rw_reg) begin
                state_next    = RD_DATA;
                sda_low_next  = ~rd_data_reg[7];
                tx_shift_next = {rd_data_reg[6:0], 1'b0};
              end else if (state_reg == DEV_ACK) begin
                state_next = WORD_ADDR;
              end else begin
                state_next = WR_DATA;
              end
            end
          end
        end
        RD_DATA: begin
          if (scl_rise) begin
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_reg == 4'd8) begin
              sda_low_next = 1'b0;
              bit_cnt_next = '0;
              state_next   = RD_ACK;
            end else begin
              sda_low_next  = ~tx_shift_reg[7];
              tx_shift_next = {tx_shift_reg[6:0], 1'b0};
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (sda_s) begin
              state_next = IDLE;
            end else begin
              addr_ptr_next = addr_ptr_reg + ADDR_W'(1);
              bit_cnt_next  = 4'd1;
            end
          end else if (scl_fall && bit_cnt_reg == 4'd1) begin
            state_next    = RD_DATA;
            bit_cnt_next  = '0;
            sda_low_next  = ~rd_data_reg[7];
            tx_shift_next = {rd_data_reg[6:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= '0;
      rx_shift_reg <= '0;
      tx_shift_reg <= '0;
      sda_low_reg  <= 1'b0;
      busy_reg     <= 1'b0;
      rw_reg       <= 1'b0;
      page_reg     <= '0;
      addr_ptr_reg <= '0;
      wr_pulse_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      rx_shift_reg <= rx_shift_next;
      tx_shift_reg <= tx_shift_next;
      sda_low_reg  <= sda_low_next;
      busy_reg     <= busy_next;
      rw_reg       <= rw_next;
      page_reg     <= page_next;
      addr_ptr_reg <= addr_ptr_next;
      wr_pulse_reg <= mem_we;
    end
  end

  // Storage keeps its contents across reset; read port is registered.
  always_ff @(posedge CLK) begin
    if (mem_we) mem_array[addr_ptr_reg] <= rx_byte;
    rd_data_reg <= mem_array[addr_ptr_reg];
  end

  assign SDA      = sda_low_reg ? 1'b0 : 1'bz;
  assign BUSY     = busy_reg;
  assign WR_PULSE = wr_pulse_reg;
  assign ADDR_PTR = addr_ptr_reg;

endmodule

// File: tb/tb_eeprom_i2c_slave.sv
// Directed bench for eeprom_i2c_slave: bit-banged I2C master with hand-computed expectations.
module tb_eeprom_i2c_slave;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        SCL = 1'b1;
  logic        m_sda_low = 1'b0;
  wire         SDA;
  logic        BUSY, WR_PULSE;
  logic [10:0] ADDR_PTR;
  int          err_cnt = 0;
  int          chk_cnt = 0;
  int          pulse_cnt = 0;
  logic [7:0]  wr_buf [4];
  logic [7:0]  rd_buf [4];

  assign SDA = m_sda_low ? 1'b0 : 1'bz;
  pullup (SDA);

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (WR_PULSE) pulse_cnt <= pulse_cnt + 1;

  eeprom_i2c_slave dut (
    .CLK(CLK),
    .RESET(RESET),
`ifdef EEPROM_SLAVE_WP_EN
    .WP(1'b0),
`endif
    .SCL(SCL),
    .SDA(SDA),
    .BUSY(BUSY),
    .WR_PULSE(WR_PULSE),
    .ADDR_PTR(ADDR_PTR)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One quarter SCL period = 4 CLK; all driving and sampling happens on CLK falling edges.
  task automatic wait_q();
    repeat (4) @(negedge CLK);
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; wait_q();
    SCL = 1'b1;       wait_q();
    m_sda_low = 1'b1; wait_q();
    SCL = 1'b0;       wait_q();
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; wait_q();
    SCL = 1'b1;       wait_q();
    m_sda_low = 1'b0; wait_q();
  endtask

  task automatic put_bit(input logic b);
    m_sda_low = ~b; wait_q();
    SCL = 1'b1;     wait_q(); wait_q();
    SCL = 1'b0;     wait_q();
  endtask

  task automatic get_bit(output logic b);
    m_sda_low = 1'b0; wait_q();
    SCL = 1'b1;       wait_q();
    b = SDA;          wait_q();
    SCL = 1'b0;       wait_q();
  endtask

  task automatic send_chk(input logic [7:0] d, input logic exp_nack, input string tag);
    logic a;
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(a);
    check_val(tag, {31'd0, a}, {31'd0, exp_nack});
  endtask

  task automatic recv_byte(input logic ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(~ack);
  endtask

  // Leaves the bus open (no STOP) so callers can inspect state first.
  task automatic write_bytes(input logic [10:0] a, input int n);
    i2c_start();
    send_chk({4'hA, a[10:8], 1'b0}, 1'b0, "wr_ctrl_ack");
    send_chk(a[7:0], 1'b0, "wr_word_ack");
    for (int i = 0; i < n; i++) send_chk(wr_buf[i], 1'b0, "wr_data_ack");
    $display("txn write addr=0x%03h bytes=%0d", a, n);
  endtask

  task automatic rand_read(input logic [10:0] a, input int n);
    i2c_start();
    send_chk({4'hA, a[10:8], 1'b0}, 1'b0, "rr_ctrl_ack");
    send_chk(a[7:0], 1'b0, "rr_word_ack");
    i2c_start();
    send_chk({4'hA, a[10:8], 1'b1}, 1'b0, "rr_rctrl_ack");
    for (int i = 0; i < n; i++) recv_byte(i < n - 1, rd_buf[i]);
    i2c_stop();
    $display("txn random read addr=0x%03h bytes=%0d first=0x%02h", a, n, rd_buf[0]);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    RESET = 1'b1;
    repeat (5) @(negedge CLK);
    check_val("rst_busy", {31'd0, BUSY}, 32'd0);
    check_val("rst_wr_pulse", {31'd0, WR_PULSE}, 32'd0);
    check_val("rst_addr_ptr", {21'd0, ADDR_PTR}, 32'h000);
    check_val("rst_sda", {31'd0, SDA}, 32'd1);
    RESET = 1'b0;
    repeat (5) @(negedge CLK);
    $display("txn reset released");

    // Byte write 0x5A to 0x123
    p0 = pulse_cnt;
    wr_buf[0] = 8'h5A;
    write_bytes(11'h123, 1);
    check_val("bw_busy_mid", {31'd0, BUSY}, 32'd1);
    i2c_stop();
    check_val("bw_busy_after", {31'd0, BUSY}, 32'd0);
    check_val("bw_pulses", pulse_cnt - p0, 32'd1);
    check_val("bw_ptr", {21'd0, ADDR_PTR}, 32'h124);

    // Random read from 0x123
    rand_read(11'h123, 1);
    check_val("rr_data", {24'd0, rd_buf[0]}, 32'h5A);
    check_val("rr_ptr", {21'd0, ADDR_PTR}, 32'h123);

    // Page-wrap write starting at 0x01E
    p0 = pulse_cnt;
    wr_buf[0] = 8'h11; wr_buf[1] = 8'h22; wr_buf[2] = 8'h33;
    write_bytes(11'h01E, 3);
    i2c_stop();
    check_val("pw_pulses", pulse_cnt - p0, 32'd3);
    check_val("pw_ptr", {21'd0, ADDR_PTR}, 32'h011);
    rand_read(11'h01E, 2);
    check_val("pw_mem_01e", {24'd0, rd_buf[0]}, 32'h11);
    check_val("pw_mem_01f", {24'd0, rd_buf[1]}, 32'h22);
    check_val("pw_rd_ptr", {21'd0, ADDR_PTR}, 32'h01F);
    rand_read(11'h010, 1);
    check_val("pw_mem_010", {24'd0, rd_buf[0]}, 32'h33);

    // Sequential read wrapping from 0x7FF to 0x000
    wr_buf[0] = 8'hC3;
    write_bytes(11'h7FF, 1);
    i2c_stop();
    wr_buf[0] = 8'h3C;
    write_bytes(11'h000, 1);
    i2c_stop();
    write_bytes(11'h7FF, 0);
    i2c_stop();
    check_val("sr_ptr_set", {21'd0, ADDR_PTR}, 32'h7FF);
    i2c_start();
    send_chk(8'hAF, 1'b0, "sr_ctrl_ack");
    recv_byte(1'b1, rd_buf[0]);
    recv_byte(1'b0, rd_buf[1]);
    i2c_stop();
    $display("txn current-address read bytes=0x%02h 0x%02h", rd_buf[0], rd_buf[1]);
    check_val("sr_mem_7ff", {24'd0, rd_buf[0]}, 32'hC3);
    check_val("sr_mem_000", {24'd0, rd_buf[1]}, 32'h3C);
    check_val("sr_ptr_end", {21'd0, ADDR_PTR}, 32'h000);

    // Device-type mismatch: no ACK, following bytes ignored
    p0 = pulse_cnt;
    i2c_start();
    send_chk(8'hB2, 1'b1, "mm_ctrl_nack");
    send_chk(8'h23, 1'b1, "mm_word_nack");
    send_chk(8'h77, 1'b1, "mm_data_nack");
    i2c_stop();
    $display("txn mismatched control byte 0xB2");
    check_val("mm_pulses", pulse_cnt - p0, 32'd0);
    check_val("mm_ptr", {21'd0, ADDR_PTR}, 32'h000);
    check_val("mm_busy", {31'd0, BUSY}, 32'd0);
    rand_read(11'h123, 1);
    check_val("mm_mem_123", {24'd0, rd_buf[0]}, 32'h5A);

    // Reset while the slave drives the first (0) bit of 0x5A
    i2c_start();
    send_chk(8'hA2, 1'b0, "rst_ctrl_ack");
    send_chk(8'h23, 1'b0, "rst_word_ack");
    i2c_start();
    send_chk(8'hA3, 1'b0, "rst_rctrl_ack");
    check_val("rst_sda_driven", {31'd0, SDA}, 32'd0);
    RESET = 1'b1;
    #1;
    check_val("rst_sda_released", {31'd0, SDA}, 32'd1);
    check_val("rst_busy_mid", {31'd0, BUSY}, 32'd0);
    check_val("rst_ptr_mid", {21'd0, ADDR_PTR}, 32'h000);
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    wait_q();
    $display("txn reset asserted mid-read");
    p0 = pulse_cnt;
    wr_buf[0] = 8'h7A;
    write_bytes(11'h055, 1);
    i2c_stop();
    check_val("post_rst_pulses", pulse_cnt - p0, 32'd1);
    rand_read(11'h055, 1);
    check_val("post_rst_mem_055", {24'd0, rd_buf[0]}, 32'h7A);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
